// File: rtl/multi_debouncer.sv
// multi_debouncer: per-channel 2-flop sync + stable-time debounce with edge strobes.
// Ports: clk, rst_n, sw_in, sw_out, rise_pulse, fall_pulse, any_change; hold_pulse with DEBOUNCE_HOLD_EN.
module multi_debouncer #(
  parameter int unsigned NUM_CH           = 4,
  parameter int unsigned CLK_FREQ_HZ      = 100_000_000,
  parameter int unsigned DEBOUNCE_TIME_MS = 20,
  parameter int unsigned HOLD_TIME_MS     = 1000,
  parameter logic [NUM_CH-1:0] RESET_VALUE = '0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NUM_CH-1:0] sw_in,
  output logic [NUM_CH-1:0] sw_out,
  output logic [NUM_CH-1:0] rise_pulse,
  output logic [NUM_CH-1:0] fall_pulse,
  output logic              any_change
`ifdef DEBOUNCE_HOLD_EN
  ,
  output logic [NUM_CH-1:0] hold_pulse
`endif
);

  localparam longint DB_CYCLES =
    longint'(DEBOUNCE_TIME_MS) * longint'(CLK_FREQ_HZ) / 1000;
  localparam longint HOLD_CYCLES =
    longint'(HOLD_TIME_MS) * longint'(CLK_FREQ_HZ) / 1000;
  localparam int CW = $clog2(DB_CYCLES + 1);
  localparam logic [CW-1:0] DB_LAST = CW'(DB_CYCLES - 1);

  if (DB_CYCLES < 1) begin : g_db_chk
    $error("multi_debouncer: debounce time below one clock");
  end
  if (NUM_CH < 1 || NUM_CH > 32) begin : g_ch_chk
    $error("multi_debouncer: NUM_CH out of range 1..32");
  end
  if (HOLD_CYCLES < 1) begin : g_hold_chk
    $error("multi_debouncer: hold time below one clock");
  end

  logic [NUM_CH-1:0] sync1;
  logic [NUM_CH-1:0] sync2;
  logic [NUM_CH-1:0] flip;
  logic [NUM_CH-1:0] sw_nxt;
  logic [CW-1:0]     cnt     [NUM_CH];
  logic [CW-1:0]     cnt_nxt [NUM_CH];

  // Counter only runs while the synced level disagrees with the output;
  // it flips the output on its last count, so it can never wrap.
  always_comb begin
    flip   = '0;
    sw_nxt = sw_out;
    for (int i = 0; i < NUM_CH; i++) begin
      cnt_nxt[i] = '0;
      if (sync2[i] != sw_out[i]) begin
        if (cnt[i] == DB_LAST) begin
          flip[i]   = 1'b1;
          sw_nxt[i] = sync2[i];
        end else begin
          cnt_nxt[i] = cnt[i] + CW'(1);
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1      <= RESET_VALUE;
      sync2      <= RESET_VALUE;
      sw_out     <= RESET_VALUE;
      rise_pulse <= '0;
      fall_pulse <= '0;
      for (int i = 0; i < NUM_CH; i++) cnt[i] <= '0;
    end else begin
      sync1      <= sw_in;
      sync2      <= sync1;
      sw_out     <= sw_nxt;
      rise_pulse <= flip & sw_nxt;
      fall_pulse <= flip & ~sw_nxt;
      for (int i = 0; i < NUM_CH; i++) cnt[i] <= cnt_nxt[i];
    end
  end

  assign any_change = |(rise_pulse | fall_pulse);

`ifdef DEBOUNCE_HOLD_EN
  localparam int HW = $clog2(HOLD_CYCLES + 1);
  localparam logic [HW-1:0] HOLD_MAX  = HW'(HOLD_CYCLES);
  localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_CYCLES - 1);

  logic [HW-1:0]     hold_cnt [NUM_CH];
  logic [HW-1:0]     hold_nxt [NUM_CH];
  logic [NUM_CH-1:0] hold_hit;

  // Count tracks the number of high cycles including the one being entered,
  // so the strobe lands in the HOLD_CYCLES-th high cycle; saturation
  // keeps it to one strobe per press.
  always_comb begin
    hold_hit = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      hold_nxt[i] = '0;
      if (sw_nxt[i]) begin
        hold_nxt[i] = (hold_cnt[i] == HOLD_MAX) ? hold_cnt[i]
                                                : hold_cnt[i] + HW'(1);
        hold_hit[i] = (hold_cnt[i] == HOLD_LAST);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hold_pulse <= '0;
      for (int i = 0; i < NUM_CH; i++) hold_cnt[i] <= '0;
    end else begin
      hold_pulse <= hold_hit;
      for (int i = 0; i < NUM_CH; i++) hold_cnt[i] <= hold_nxt[i];
    end
  end
`endif

endmodule

// File: tb/tb_multi_debouncer.sv
// tb_multi_debouncer: directed stimulus, run-length model, per-cycle compare.
// Build with DEBOUNCE_HOLD_EN defined to also exercise hold_pulse.
module tb_multi_debouncer;

  localparam int NCH = 4;
  localparam int DB  = 4;
  localparam int HC  = 10;

  logic           clk = 1'b0;
  logic           rst_n;
  logic [NCH-1:0] sw_in;
  logic [NCH-1:0] sw_out;
  logic [NCH-1:0] rise_pulse;
  logic [NCH-1:0] fall_pulse;
  logic           any_change;
  logic [NCH-1:0] hold_pulse;

  int n_chk  = 0;
  int n_fail = 0;
  bit cmp_en = 1'b0;

  always #5 clk = ~clk;

  multi_debouncer #(
    .NUM_CH(NCH),
    .CLK_FREQ_HZ(1000),
    .DEBOUNCE_TIME_MS(4),
    .HOLD_TIME_MS(10),
    .RESET_VALUE('0)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .sw_in(sw_in),
    .sw_out(sw_out),
    .rise_pulse(rise_pulse),
    .fall_pulse(fall_pulse),
    .any_change(any_change)
`ifdef DEBOUNCE_HOLD_EN
    ,
    .hold_pulse(hold_pulse)
`endif
  );

`ifndef DEBOUNCE_HOLD_EN
  assign hold_pulse = '0;
`endif

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Model: an input level must be seen (after 2 sync cycles) for DB
  // consecutive cycles before the output adopts it.
  logic [NCH-1:0] h0, h1, m_out, m_rise, m_fall, m_hold;
  int run [NCH];
  int hi  [NCH];

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      h0 = '0; h1 = '0; m_out = '0;
      m_rise = '0; m_fall = '0; m_hold = '0;
      for (int i = 0; i < NCH; i++) begin
        run[i] = 0;
        hi[i]  = 0;
      end
    end else begin
      m_rise = '0; m_fall = '0; m_hold = '0;
      for (int i = 0; i < NCH; i++) begin
        run[i] = (h1[i] != m_out[i]) ? run[i] + 1 : 0;
        if (run[i] == DB) begin
          m_out[i] = h1[i];
          run[i]   = 0;
          if (h1[i]) m_rise[i] = 1'b1;
          else       m_fall[i] = 1'b1;
        end
        if (m_out[i]) begin
          hi[i]++;
          if (hi[i] == HC) m_hold[i] = 1'b1;
        end else begin
          hi[i] = 0;
        end
      end
      h1 = h0;
      h0 = sw_in;
    end
  end

  always @(negedge clk) begin
    if (cmp_en) begin
      chk("m_sw_out", 32'(sw_out), 32'(m_out));
      chk("m_rise", 32'(rise_pulse), 32'(m_rise));
      chk("m_fall", 32'(fall_pulse), 32'(m_fall));
      chk("m_any", 32'(any_change), 32'(|(m_rise | m_fall)));
`ifdef DEBOUNCE_HOLD_EN
      chk("m_hold", 32'(hold_pulse), 32'(m_hold));
`endif
    end
  end

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    rst_n = 1'b0;
    sw_in = '0;
    step(3);
    chk("rst_sw_out", 32'(sw_out), 32'h0);
    chk("rst_pulses", 32'({rise_pulse, fall_pulse, any_change}), 32'h0);
    rst_n  = 1'b1;
    cmp_en = 1'b1;
    step(2);

    // single-cycle glitch is rejected
    sw_in = 4'b0001;
    step(1);
    sw_in = 4'b0000;
    step(10);
    chk("glitch_out", 32'(sw_out), 32'h0);

    // clean step, 6-cycle latency, one-cycle strobe
    sw_in = 4'b0001;
    step(5);
    chk("step_pre", 32'(sw_out), 32'h0);
    step(1);
    chk("step_out", 32'(sw_out), 32'h1);
    chk("step_rise", 32'(rise_pulse), 32'h1);
    chk("step_any", 32'(any_change), 32'h1);
    step(1);
    chk("step_rise_end", 32'(rise_pulse), 32'h0);
    chk("step_any_end", 32'(any_change), 32'h0);

    // bounce on ch1: 3 high, 1 low, then held
    sw_in = 4'b0011;
    step(3);
    sw_in = 4'b0001;
    step(1);
    sw_in = 4'b0011;
    step(5);
    chk("bounce_pre", 32'(sw_out), 32'h1);
    step(1);
    chk("bounce_out", 32'(sw_out), 32'h3);
    chk("bounce_rise", 32'(rise_pulse), 32'h2);

    sw_in = 4'b0000;
    step(8);
    chk("idle_out", 32'(sw_out), 32'h0);

    // all channels together
    sw_in = 4'b1111;
    step(6);
    chk("all_rise", 32'(rise_pulse), 32'hf);
    chk("all_out", 32'(sw_out), 32'hf);
    step(1);
    chk("all_rise_end", 32'(rise_pulse), 32'h0);
    sw_in = 4'b0000;
    step(5);
    chk("all_fall_pre", 32'(fall_pulse), 32'h0);
    step(1);
    chk("all_fall", 32'(fall_pulse), 32'hf);
    chk("all_fall_out", 32'(sw_out), 32'h0);
    step(2);

    // reset mid-count on ch2
    sw_in = 4'b0100;
    step(4);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_out", 32'(sw_out), 32'h0);
    chk("mid_rst_pls", 32'({rise_pulse, fall_pulse, any_change}), 32'h0);
    step(1);
    rst_n = 1'b1;
    step(5);
    chk("post_rst_pre", 32'(sw_out), 32'h0);
    step(1);
    chk("post_rst_out", 32'(sw_out), 32'h4);
    chk("post_rst_rise", 32'(rise_pulse), 32'h4);
    sw_in = 4'b0000;
    step(8);

`ifdef DEBOUNCE_HOLD_EN
    // long press on ch3, then re-press
    for (int k = 0; k < 2; k++) begin
      sw_in = 4'b1000;
      step(6);
      chk("hold_out", 32'(sw_out), 32'h8);
      step(8);
      chk("hold_pre", 32'(hold_pulse), 32'h0);
      step(1);
      chk("hold_pulse", 32'(hold_pulse), 32'h8);
      step(1);
      chk("hold_end", 32'(hold_pulse), 32'h0);
      step(15);
      sw_in = 4'b0000;
      step(8);
    end
`endif

    step(2);
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
